dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the dmem and bmem ports.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: flush  in  1  core pipeline flush; dmem_addr  in  ADDR_W  request byte address; dmem_rmask  in  4  load byte mask; dmem_wmask  in  4  store byte mask; dmem_wdata  in  32  store data.
REQ-004 SHALL have ports: dmem_rdata  out  32  load data; dmem_resp  out  1  request complete.
REQ-005 SHALL have ports: bmem_addr  out  ADDR_W  beat address; bmem_read  out  1  read strobe; bmem_write  out  1  write strobe; bmem_wdata  out  64  write beat; bmem_ready  in  1  memory accepts; bmem_raddr  in  ADDR_W  returned-beat address; bmem_rdata  in  64  returned beat; bmem_rvalid  in  1  beat valid.

Function
REQ-006 SHALL accept a request in IDLE when dmem_rmask or dmem_wmask is nonzero; the requester holds address, masks and wdata stable until dmem_resp.
REQ-007 SHALL latch the request at acceptance; the latched copy, not the live inputs, drives all later states.
REQ-008 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
REQ-009 SHALL drive bmem_addr = {addr[ADDR_W-1:3], 3'b000} and select the word with addr[2] (0 = bits 31:0, 1 = bits 63:32).
REQ-010 Load: IDLE->RD_REQ; bmem_read pulses for exactly one cycle, in the first cycle bmem_ready=1; ->RD_WAIT.
REQ-011 RD_WAIT SHALL ignore rvalid beats whose bmem_raddr differs from the latched beat address; on a match, capture the selected word and go to RESP.
REQ-012 Store: IDLE->RD_REQ->RD_WAIT read-modify-write; on the matching beat, merge wmask bytes into the selected word and go to WR_REQ.
REQ-013 WR_REQ SHALL hold bmem_write=1 with the merged beat until a cycle with bmem_ready=1, then go to RESP.
REQ-014 RESP SHALL assert dmem_resp for exactly one cycle and return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-015 dmem_rdata SHALL hold the full selected 32-bit word, unmasked, from the RESP cycle until the next load's RESP; it is 0 after stores.
REQ-016 A load with flush=1 in any cycle from acceptance through RESP SHALL finish its bmem transaction and go to IDLE without dmem_resp; flush SHALL NOT affect stores.
REQ-017 If both masks are nonzero, the request SHALL be treated as a store.
REQ-018 Minimum load latency SHALL be 3 cycles from acceptance to dmem_resp when bmem_ready=1 and rvalid returns in the cycle after the strobe.

Reset
REQ-019 On rst: state IDLE; dmem_resp, bmem_read, bmem_write = 0; dmem_rdata, bmem_addr, bmem_wdata, latched request = 0; buffer invalid.
REQ-020 Reset asserted mid-transaction SHALL abandon it immediately; late rvalid beats SHALL be ignored once in IDLE.

Configuration
REQ-021 With DMEM_BEAT_BUF_EN defined, a one-entry beat buffer (beat address, 64-bit data, valid) SHALL be filled by every matching read beat and updated by every store merge.
REQ-022 With DMEM_BEAT_BUF_EN defined, a load that hits the valid buffer SHALL go IDLE->RESP (dmem_resp 1 cycle after acceptance) with no bmem traffic; a store that hits SHALL skip RD_REQ/RD_WAIT.
REQ-023 Without DMEM_BEAT_BUF_EN, no buffer SHALL exist and every access SHALL use bmem.

Structure
REQ-024 The state enum and the beat-address/word-select helper constants SHALL live in the shared rv32i_types package.
REQ-025 Byte merging SHALL be a sub-module dmem_byte_merge (64-bit beat, addr[2], wmask, wdata -> merged beat).

Verification
REQ-026 Load 0x0000_1004, rmask=4'hF, beat 0x1111_2222_3333_4444 -> dmem_rdata=0x1111_2222, dmem_resp one cycle.
REQ-027 Store 0x1000, wmask=4'b0011, wdata=0xAAAA_BBBB over beat 0x1111_2222_3333_4444 -> bmem_wdata=0x1111_2222_3333_BBBB.
REQ-028 Load with bmem_ready low 5 cycles -> single bmem_read pulse after ready rises; a stray rvalid beat at 0x2000 is ignored.
REQ-029 flush pulsed during RD_WAIT of load -> no dmem_resp, FSM in IDLE; next load completes normally.
REQ-030 rst asserted in WR_REQ -> bmem_write=0 at once, all outputs 0.
REQ-031 DMEM_BEAT_BUF_EN: two loads to 0x1000 then 0x1004 -> second responds 1 cycle after acceptance with no bmem_read.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared FSM state encoding, beat/word geometry constants and the
// word-select helper used by the data-memory responder.
package rv32i_types;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } dmem_state_e;

  // A beat is 64 bits (8 bytes): the low 3 address bits index inside it.
  localparam int unsigned BEAT_OFFSET_W = 3;
  // Address bit that picks the 32-bit word within a beat.
  localparam int unsigned WORD_SEL_BIT  = 2;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BEAT_W        = 64;

  // Pick the 32-bit word of a beat: sel=0 -> bits 31:0, sel=1 -> bits 63:32.
  function automatic logic [WORD_W-1:0] select_word(input logic [BEAT_W-1:0] beat,
                                                    input logic              sel);
    return sel ? beat[BEAT_W-1:WORD_W] : beat[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: writes the enabled bytes of a 32-bit store into the
// selected word of a 64-bit beat; all other bytes pass through unchanged.
module dmem_byte_merge
  import rv32i_types::*;
(
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              word_sel_i,
  input  logic [3:0]        wmask_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [BEAT_W-1:0] beat_o
);

  // Overwrite only the masked bytes of the chosen word.
  always_comb begin
    beat_o = beat_i;
    for (int b = 0; b < 4; b++) begin
      if (wmask_i[b]) begin
        if (word_sel_i) begin
          beat_o[WORD_W + 8*b +: 8] = wdata_i[8*b +: 8];
        end else begin
          beat_o[8*b +: 8] = wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: turns 32-bit core load/store requests into 64-bit beat
// transactions. Loads read one beat; stores do read-modify-write. Optional
// one-entry beat buffer enabled by the DMEM_BEAT_BUF_EN macro.
//
// Handshakes:
//   core side  - a request is offered while dmem_rmask|dmem_wmask is nonzero
//                and held stable until the single-cycle dmem_resp pulse.
//   bmem read  - bmem_read is high only in a cycle where bmem_ready is high;
//                that cycle is the transfer. Beats return later on
//                bmem_rvalid tagged with bmem_raddr; only a tag equal to the
//                outstanding beat address is consumed.
//   bmem write - bmem_write and bmem_wdata are held until a cycle with
//                bmem_ready high; that cycle is the transfer.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [3:0]        dmem_rmask,
  input  logic [3:0]        dmem_wmask,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  output logic              dmem_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [63:0]       bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [63:0]       bmem_rdata,
  input  logic              bmem_rvalid,
  output logic [2:0]        dbg_state_o
);

  // FSM state and the request latched at acceptance.
  dmem_state_e       state_q;
  logic [ADDR_W-1:0] beat_addr_q;
  logic              word_sel_q;
  logic [3:0]        wmask_q;
  logic [31:0]       wdata_q;
  logic              is_store_q;
  logic              flushed_q;

  // Registered outputs.
  logic [31:0]       rdata_q;
  logic              resp_q;
  logic              write_q;
  logic [63:0]       wbeat_q;

  // Live-request decode, used only in IDLE.
  logic              req_valid;
  logic              req_store;
  logic [ADDR_W-1:0] req_beat;
  logic              beat_match;
  logic              load_flush;

  // Low address bits only select bytes via the masks.
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^dmem_addr[1:0];

  assign req_valid  = (|dmem_rmask) | (|dmem_wmask);
  // A request with any write byte enabled is a store, even if rmask is set.
  assign req_store  = |dmem_wmask;
  assign req_beat   = {dmem_addr[ADDR_W-1:BEAT_OFFSET_W], {BEAT_OFFSET_W{1'b0}}};
  assign beat_match = bmem_rvalid && (bmem_raddr == beat_addr_q);
  // Flush only ever cancels loads.
  assign load_flush = flush & ~is_store_q;

  // Beat buffer: last beat seen, so repeated accesses to it skip the read.
  logic              buf_hit;
  logic [63:0]       buf_beat;

`ifdef DMEM_BEAT_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [63:0]       buf_data_q;

  assign buf_hit  = buf_valid_q && (buf_addr_q == req_beat);
  assign buf_beat = buf_data_q;
`else
  assign buf_hit  = 1'b0;
  assign buf_beat = '0;
`endif

  // Merge source: the buffered beat with live inputs on an IDLE store hit,
  // otherwise the returning bmem beat with the latched request.
  logic [63:0] merge_src;
  logic        merge_sel;
  logic [3:0]  merge_wmask;
  logic [31:0] merge_wdata;
  logic [63:0] merged_beat;

  // Select merge operands depending on which path produces the old beat.
  always_comb begin
    merge_src   = bmem_rdata;
    merge_sel   = word_sel_q;
    merge_wmask = wmask_q;
    merge_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      merge_src   = buf_beat;
      merge_sel   = dmem_addr[WORD_SEL_BIT];
      merge_wmask = dmem_wmask;
      merge_wdata = dmem_wdata;
    end
  end

  dmem_byte_merge u_merge (
    .beat_i     (merge_src),
    .word_sel_i (merge_sel),
    .wmask_i    (merge_wmask),
    .wdata_i    (merge_wdata),
    .beat_o     (merged_beat)
  );

`ifdef DMEM_BEAT_BUF_EN
  // Buffer fill on every matching read beat and update on every store merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (state_q == ST_RD_WAIT && beat_match) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= beat_addr_q;
      buf_data_q  <= is_store_q ? merged_beat : bmem_rdata;
    end else if (state_q == ST_IDLE && req_valid && req_store && buf_hit) begin
      buf_data_q  <= merged_beat;
    end
  end
`endif

  // Responder FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_addr_q <= '0;
      word_sel_q  <= 1'b0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      flushed_q   <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      write_q     <= 1'b0;
      wbeat_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            beat_addr_q <= req_beat;
            word_sel_q  <= dmem_addr[WORD_SEL_BIT];
            wmask_q     <= dmem_wmask;
            wdata_q     <= dmem_wdata;
            is_store_q  <= req_store;
            flushed_q   <= flush & ~req_store;
            if (buf_hit) begin
              if (req_store) begin
                wbeat_q <= merged_beat;
                write_q <= 1'b1;
                state_q <= ST_WR_REQ;
              end else if (!flush) begin
                rdata_q <= select_word(buf_beat, dmem_addr[WORD_SEL_BIT]);
                resp_q  <= 1'b1;
                state_q <= ST_RESP;
              end
              // A flushed load hit needs no bmem work: stay in IDLE.
            end else begin
              state_q <= ST_RD_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          flushed_q <= flushed_q | load_flush;
          if (bmem_ready) begin
            state_q <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (beat_match) begin
            if (is_store_q) begin
              wbeat_q <= merged_beat;
              write_q <= 1'b1;
              state_q <= ST_WR_REQ;
            end else if (flushed_q || load_flush) begin
              // Cancelled load: beat consumed, nothing reported.
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= select_word(bmem_rdata, word_sel_q);
              resp_q  <= 1'b1;
              state_q <= ST_RESP;
            end
          end else begin
            flushed_q <= flushed_q | load_flush;
          end
        end

        ST_WR_REQ: begin
          if (bmem_ready) begin
            write_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b1;
            state_q <= ST_RESP;
          end
        end

        ST_RESP: begin
          resp_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          resp_q  <= 1'b0;
          write_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_rdata  = rdata_q;
  // A flush arriving in the RESP cycle of a load still suppresses it.
  assign dmem_resp   = resp_q & ~load_flush;
  assign bmem_addr   = beat_addr_q;
  // The read strobe is the transfer cycle itself, so it follows ready.
  assign bmem_read   = (state_q == ST_RD_REQ) & bmem_ready;
  assign bmem_write  = write_q;
  assign bmem_wdata  = wbeat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + small random bench for dmem_responder with a
// behavioural beat memory and expected-value queues.
module tb_dmem_responder;
  import rv32i_types::*;

`ifdef DMEM_BEAT_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flush;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read, bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic [2:0]  dbg_state;

  dmem_responder #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .dbg_state_o(dbg_state)
  );

  // Scoreboard state
  logic [31:0] exp_q[$];
  logic [63:0] wexp_q[$];
  logic [31:0] waddr_q[$];
  bit   [63:0] mem [bit [31:0]];
  int checks = 0;
  int errors = 0;
  int n_reads = 0, n_resp = 0;
  bit resp_seen = 0;
  bit pend = 0;
  int pend_cnt = 0;
  logic [31:0] pend_addr;
  int rdelay = 0;
  bit stray_en = 0;
  bit tb_buf_valid = 0;
  logic [31:0] tb_buf_addr = '0;
  logic [31:0] tb_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // One clock: sample DUT at negedge, then drive the bmem return beat.
  task automatic tick();
    logic [63:0] e;
    logic [31:0] ea;
    @(negedge clk);
    if (bmem_read) begin
      chk("read_only_when_ready", 64'(bmem_ready), 64'd1);
      n_reads++;
      pend      = 1'b1;
      pend_cnt  = rdelay;
      pend_addr = bmem_addr;
    end
    if (bmem_write && bmem_ready) begin
      if (wexp_q.size() == 0) begin
        chk("write_unexpected", 64'(bmem_write), 64'd0);
      end else begin
        e  = wexp_q.pop_front();
        ea = waddr_q.pop_front();
        chk("bmem_wdata", bmem_wdata, e);
        chk("bmem_waddr", 64'(bmem_addr), 64'(ea));
        mem[ea] = e;
      end
    end
    if (dmem_resp) begin
      n_resp++;
      resp_seen = 1'b1;
      if (exp_q.size() == 0) chk("resp_unexpected", 64'(dmem_resp), 64'd0);
      else chk("dmem_rdata", 64'(dmem_rdata), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    if (pend) begin
      if (pend_cnt == 0) begin
        bmem_rvalid = 1'b1;
        bmem_raddr  = pend_addr;
        bmem_rdata  = mem_rd(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
        if (stray_en) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = 32'h0000_2000;
          bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        end
      end
    end
  endtask

  // Driver: one complete request with expectations derived from the model.
  task automatic do_op(input string tag, input logic [31:0] addr, input logic [3:0] rmask,
                       input logic [3:0] wmask, input logic [31:0] wdata, input int low_ticks);
    logic [31:0] beat_a;
    logic [63:0] beat, merged;
    bit store, hit;
    int exp_lat, cnt, reads0, resp0, base;
    beat_a = {addr[31:3], 3'b000};
    beat   = mem_rd(beat_a);
    store  = (wmask != 4'h0);
    hit    = BUF_EN && tb_buf_valid && (tb_buf_addr == beat_a);
    base   = addr[2] ? 32 : 0;
    if (store) begin
      merged = beat;
      for (int b = 0; b < 4; b++)
        if (wmask[b]) merged[base + 8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back(32'h0);
      wexp_q.push_back(merged);
      waddr_q.push_back(beat_a);
      tb_rdata = 32'h0;
      exp_lat  = hit ? 2 : 4 + rdelay;
      if (low_ticks > 1) exp_lat += low_ticks - 1;
    end else begin
      tb_rdata = addr[2] ? beat[63:32] : beat[31:0];
      exp_q.push_back(tb_rdata);
      exp_lat  = hit ? 1 : 3 + rdelay;
      if (!hit && low_ticks > 1) exp_lat += low_ticks - 1;
    end
    tb_buf_valid = 1'b1;
    tb_buf_addr  = beat_a;
    reads0 = n_reads;
    resp0  = n_resp;
    dmem_addr  = addr;
    dmem_rmask = rmask;
    dmem_wmask = wmask;
    dmem_wdata = wdata;
    bmem_ready = (low_ticks == 0);
    cnt = 0;
    resp_seen = 1'b0;
    while (!resp_seen && cnt < 60) begin
      tick();
      cnt++;
      if (cnt >= low_ticks) bmem_ready = 1'b1;
    end
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    chk({tag, "_latency"}, 64'(cnt - 1), 64'(exp_lat));
    tick();
    chk({tag, "_resp_count"}, 64'(n_resp - resp0), 64'd1);
    chk({tag, "_reads"}, 64'(n_reads - reads0), hit ? 64'd0 : 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads0, resp0;
    rst = 1'b1; flush = 1'b0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    mem[32'h1000] = 64'h1111_2222_3333_4444;
    mem[32'h1008] = 64'h5555_6666_7777_8888;
    mem[32'h3000] = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp",   64'(dmem_resp), 64'd0);
    chk("rst_read",   64'(bmem_read), 64'd0);
    chk("rst_write",  64'(bmem_write), 64'd0);
    chk("rst_rdata",  64'(dmem_rdata), 64'd0);
    chk("rst_baddr",  64'(bmem_addr), 64'd0);
    chk("rst_wdata",  bmem_wdata, 64'd0);
    chk("rst_state",  64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Basic load of the upper word, then store RMW of the lower word.
    do_op("load_1004", 32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
    do_op("store_1000", 32'h0000_1000, 4'h0, 4'b0011, 32'hAAAA_BBBB, 0);
    do_op("load_1000", 32'h0000_1000, 4'hF, 4'h0, 32'h0, 0);

    // Ready low five cycles, late beat with stray beats at 0x2000 before it.
    rdelay = 2; stray_en = 1'b1;
    do_op("load_ready_low", 32'h0000_1008, 4'hF, 4'h0, 32'h0, 6);
    rdelay = 3; stray_en = 1'b0;

    // Flush in RD_WAIT: no response, transaction still finishes.
    reads0 = n_reads; resp0 = n_resp;
    dmem_addr = 32'h0000_1000; dmem_rmask = 4'hF; bmem_ready = 1'b1;
    tick(); tick();
    chk("flush_pre_state", 64'(dbg_state), 64'(ST_RD_WAIT));
    flush = 1'b1; dmem_rmask = 4'h0;
    tick();
    flush = 1'b0;
    repeat (8) tick();
    chk("flush_no_resp", 64'(n_resp - resp0), 64'd0);
    chk("flush_reads", 64'(n_reads - reads0), 64'd1);
    chk("flush_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("flush_rdata_hold", 64'(dmem_rdata), 64'(tb_rdata));
    tb_buf_valid = 1'b1; tb_buf_addr = 32'h0000_1000;
    rdelay = 0;
    do_op("after_flush", 32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);

    // Reset while a write is waiting for ready.
    dmem_addr = 32'h0000_3000; dmem_wmask = 4'hF; dmem_wdata = 32'hCAFE_F00D;
    bmem_ready = 1'b1;
    tick(); tick();
    bmem_ready = 1'b0;
    tick();
    chk("wr_req_state", 64'(dbg_state), 64'(ST_WR_REQ));
    chk("wr_req_write", 64'(bmem_write), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_write", 64'(bmem_write), 64'd0);
    chk("rst_mid_resp",  64'(dmem_resp), 64'd0);
    chk("rst_mid_baddr", 64'(bmem_addr), 64'd0);
    chk("rst_mid_wdata", bmem_wdata, 64'd0);
    chk("rst_mid_rdata", 64'(dmem_rdata), 64'd0);
    chk("rst_mid_state", 64'(dbg_state), 64'(ST_IDLE));
    dmem_wmask = 4'h0; bmem_ready = 1'b1;
    tb_buf_valid = 1'b0; tb_rdata = 32'h0;
    tick();
    rst = 1'b0;
    // Late beat arriving in IDLE is ignored.
    resp0 = n_resp;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0; bmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick();
    chk("late_beat_no_resp", 64'(n_resp - resp0), 64'd0);
    chk("late_beat_state", 64'(dbg_state), 64'(ST_IDLE));

    // Same-beat pair of loads (buffer hit on the second when enabled).
    do_op("pair_first", 32'h0000_1000, 4'hF, 4'h0, 32'h0, 0);
    do_op("pair_second", 32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);

    // Short random mix; both masks set must behave as a store.
    for (int i = 0; i < 8; i++) begin
      int kind;
      logic [31:0] a;
      logic [3:0] rm, wm;
      a    = 32'h0000_1000 + 32'($urandom_range(0, 15) << 2);
      kind = $urandom_range(0, 2);
      rm   = (kind == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      wm   = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_op("rand_op", a, rm, wm, $urandom, $urandom_range(0, 2));
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("wexp_q_drained", 64'(wexp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
